// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//
// Contents:
//   UART_DATA_BITS        data bits per frame (8)
//   DEFAULT_CLKS_PER_BIT  bit period in clocks for 115200 baud at 50 MHz
//   tx_state_t            transmitter FSM states
//   even_parity()         even parity of one data byte
//
// Build option: UART_TX_PARITY_EN adds a PARITY state (8E1 framing).
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push         write i_wdata (ignored while full)
//   i_pop          advance the read pointer (ignored while empty)
//   i_wdata        write data
//   o_rdata        head entry, valid whenever !o_empty
//   o_full         no free entries
//   o_empty        no stored entries
//   o_count        registered number of stored entries (0..DEPTH)
//
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_wdata,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; it carries no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/serial_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 (or 8E1) serializer, LSB first.
//
// Ports:
//   Clk           system clock
//   Reset         asynchronous active-high reset
//   tx_data       byte to enqueue
//   tx_valid      producer has a byte on tx_data
//   tx_ready      FIFO can accept a byte this cycle (!full)
//   overflow_clr  clears the sticky overflow flag
//   txd           serial line, idle high, registered
//   busy          a frame is in progress
//   fifo_count    bytes queued (excluding the one being shifted)
//   overflow      sticky: a byte was offered while full and dropped
//
// Build option: define UART_TX_PARITY_EN to insert an even parity bit
// between the data bits and the stop bit.
module serial_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  input  logic                              overflow_clr,
  output logic                              txd,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic [UART_DATA_BITS-1:0] w_head;

  tx_state_t                 r_state, w_state_nxt;
  logic [BAUD_W-1:0]         r_baud,  w_baud_nxt;
  logic [IDX_W-1:0]          r_idx,   w_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                      r_txd,   w_txd_nxt;
  logic                      r_busy;
  logic                      r_arm;
  logic                      r_overflow;
  logic                      w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity, w_parity_nxt;
`endif

  assign w_push    = tx_valid && !w_full;
  assign w_bit_end = (r_baud == BAUD_LAST);

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (tx_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // Next-state logic. From IDLE a pop waits for r_arm, a registered copy of
  // !empty, so the first start bit lands two edges after the accepting edge.
  // From STOP the next byte is taken directly, giving back-to-back frames.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BAUD_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (r_arm && !w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_baud_nxt  = '0;
          w_idx_nxt   = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_baud_nxt  = '0;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_baud_nxt  = '0;
      end
    endcase
  end

`ifdef UART_TX_PARITY_EN
  assign w_parity_nxt = w_pop ? even_parity(w_head) : r_parity;
`endif

  // Line level is decoded from the next state so txd can be a plain flop.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_txd_nxt = w_parity_nxt;
`endif
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_idx      <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_arm      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_idx   <= w_idx_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_arm   <= !w_empty;
      // A drop in the same cycle as a clear keeps the flag set.
      if (tx_valid && w_full)  r_overflow <= 1'b1;
      else if (overflow_clr)   r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    r_shift <= w_shift_nxt;
`ifdef UART_TX_PARITY_EN
    r_parity <= w_parity_nxt;
`endif
  end

  assign tx_ready = !w_full;
  assign txd      = r_txd;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule
